// File: rtl/noc_output_arbiter.sv
// Wormhole output-port arbiter: round-robin choice among input flit queues,
// grant held from head to tail, popped flit forwarded on a registered link.
module noc_output_arbiter #(
   parameter int N_PORTS = 5,
   parameter int FLIT_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_PORTS-1:0]        req_i,
   input  logic [N_PORTS*FLIT_W-1:0] data_i,
   input  logic                      ready_i,
   output logic [N_PORTS-1:0]        pop_req_o,
   output logic [FLIT_W-1:0]         data_o,
   output logic                      valid_o,
   output logic [N_PORTS-1:0]        grant_o,
   output logic                      busy_o,
   output logic                      proto_err_o
);

   localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   localparam logic S_IDLE   = 1'b0;
   localparam logic S_LOCKED = 1'b1;

   localparam logic [1:0] T_HEAD   = 2'b01;
   localparam logic [1:0] T_TAIL   = 2'b10;
   localparam logic [1:0] T_SINGLE = 2'b11;

   logic              r_state;
   logic [PTR_W-1:0]  r_rr_ptr;
   logic [PTR_W-1:0]  r_owner;
   logic [FLIT_W-1:0] r_data;
   logic              r_valid;
   logic              r_proto_err;

   logic [N_PORTS-1:0] w_eligible;
   logic [N_PORTS-1:0] w_bad_head;
   logic               w_found;
   logic [PTR_W-1:0]   w_winner;
   logic [PTR_W:0]     w_idx;
   logic [PTR_W-1:0]   w_sel;
   logic               w_pop;
   logic [FLIT_W-1:0]  w_sel_flit;
   logic [1:0]         w_sel_type;
   logic [N_PORTS-1:0] w_pop_vec;
   logic [N_PORTS-1:0] w_grant;

   function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
      if (int'(p) == N_PORTS - 1) return '0;
      return p + PTR_W'(1);
   endfunction

   // Type bit FLIT_W-2 is set exactly for head (01) and single (11) flits.
   always_comb begin
      w_eligible = '0;
      w_bad_head = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         w_eligible[k] = req_i[k] &  data_i[k*FLIT_W + FLIT_W - 2];
         w_bad_head[k] = req_i[k] & ~data_i[k*FLIT_W + FLIT_W - 2];
      end
   end

   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         w_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
         if (w_idx >= (PTR_W+1)'(N_PORTS)) w_idx = w_idx - (PTR_W+1)'(N_PORTS);
         if (!w_found && w_eligible[w_idx[PTR_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_idx[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      if (r_state == S_IDLE) begin
         w_sel = w_winner;
         w_pop = w_found & ready_i & ~rst;
      end else begin
         w_sel = r_owner;
         w_pop = req_i[r_owner] & ready_i & ~rst;
      end
      w_sel_flit = data_i[int'(w_sel)*FLIT_W +: FLIT_W];
      w_sel_type = w_sel_flit[FLIT_W-1 -: 2];
      w_pop_vec  = w_pop ? (N_PORTS'(1) << w_sel) : '0;
      w_grant    = (r_state == S_LOCKED) ? (N_PORTS'(1) << r_owner) : w_pop_vec;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_rr_ptr    <= '0;
         r_owner     <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         r_valid <= w_pop;
         if (w_pop) r_data <= w_sel_flit;
         if (r_state == S_IDLE) begin
            if (|w_bad_head) r_proto_err <= 1'b1;
            if (w_pop) begin
               if (w_sel_type == T_SINGLE) begin
                  r_rr_ptr <= f_inc(w_winner);
               end else begin
                  r_state <= S_LOCKED;
                  r_owner <= w_winner;
               end
            end
         end else if (w_pop) begin
            // A head or single inside a locked packet is flagged but still forwarded.
            if (w_sel_type == T_TAIL) begin
               r_state  <= S_IDLE;
               r_rr_ptr <= f_inc(r_owner);
            end else if (w_sel_type == T_HEAD || w_sel_type == T_SINGLE) begin
               r_proto_err <= 1'b1;
            end
         end
      end
   end

   assign pop_req_o   = w_pop_vec;
   assign grant_o     = rst ? '0 : w_grant;
   assign busy_o      = (r_state == S_LOCKED) & ~rst;
   assign data_o      = r_data;
   assign valid_o     = r_valid;
   assign proto_err_o = r_proto_err;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Randomized scoreboard bench for noc_output_arbiter against a packet-level
// reference model driven by per-port flit queues.
module tb_noc_output_arbiter;
   localparam int N = 5;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_i;
   logic [N*W-1:0] data_i;
   logic           ready_i;
   logic [N-1:0]   pop_req_o;
   logic [W-1:0]   data_o;
   logic           valid_o;
   logic [N-1:0]   grant_o;
   logic           busy_o;
   logic           proto_err_o;

   noc_output_arbiter #(.N_PORTS(N), .FLIT_W(W)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .data_i(data_i), .ready_i(ready_i),
      .pop_req_o(pop_req_o), .data_o(data_o), .valid_o(valid_o),
      .grant_o(grant_o), .busy_o(busy_o), .proto_err_o(proto_err_o)
   );

   always #5 clk = ~clk;

   logic [W-1:0] fq [N][$];
   logic [W-1:0] sb [$];
   logic [W-1:0] mon_exp;
   int errors = 0;
   int checks = 0;
   int m_owner = -1;
   int m_rr = 0;
   bit m_err = 1'b0;
   int ready_pct = 100;
   int hide_pct = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      for (int k = 0; k < N; k++) begin
         if (fq[k].size() > 0) begin
            data_i[k*W +: W] = fq[k][0];
            req_i[k] = ($urandom_range(99) >= hide_pct);
         end else begin
            data_i[k*W +: W] = W'($urandom);
            req_i[k] = 1'b0;
         end
      end
      ready_i = ($urandom_range(99) < ready_pct);
   endtask

   task automatic push_pkt(input int k, input int len);
      logic [1:0] t;
      for (int i = 0; i < len; i++) begin
         if (len == 1) t = 2'b11;
         else if (i == 0) t = 2'b01;
         else if (i == len - 1) t = 2'b10;
         else t = 2'b00;
         fq[k].push_back({t, 14'($urandom)});
      end
   endtask

   // Model evaluates the settled inputs at negedge; DUT pops on the next posedge.
   task automatic step();
      int pk;
      int q;
      bit new_err;
      logic [1:0] t;
      logic [N-1:0] eg;
      logic [N-1:0] ep;
      logic eb;
      @(negedge clk);
      pk = -1;
      new_err = 1'b0;
      eg = '0;
      if (rst) begin
         m_owner = -1;
         m_rr = 0;
         m_err = 1'b0;
      end
      eb = (m_owner >= 0);
      if (!rst && m_owner < 0) begin
         for (int k = 0; k < N; k++) begin
            t = data_i[k*W + W - 2 +: 2];
            if (req_i[k] && (t == 2'b00 || t == 2'b10)) new_err = 1'b1;
         end
         if (ready_i) begin
            for (int i = 0; i < N; i++) begin
               q = (m_rr + i) % N;
               t = data_i[q*W + W - 2 +: 2];
               if (pk < 0 && req_i[q] && (t == 2'b01 || t == 2'b11)) pk = q;
            end
         end
         if (pk >= 0) eg = 5'b1 << pk;
      end else if (!rst) begin
         eg = 5'b1 << m_owner;
         if (req_i[m_owner] && ready_i) pk = m_owner;
      end
      ep = (pk >= 0) ? (5'b1 << pk) : 5'b0;
      chk("pop_req_o", 32'(pop_req_o), 32'(ep));
      chk("grant_o", 32'(grant_o), 32'(eg));
      chk("busy_o", 32'(busy_o), 32'(eb));
      chk("proto_err_o", 32'(proto_err_o), 32'(m_err));
      if (new_err) m_err = 1'b1;
      if (pk >= 0) begin
         sb.push_back(data_i[pk*W +: W]);
         t = data_i[pk*W + W - 2 +: 2];
         void'(fq[pk].pop_front());
         if (m_owner < 0) begin
            if (t == 2'b11) m_rr = (pk + 1) % N;
            else m_owner = pk;
         end else if (t == 2'b10) begin
            m_rr = (m_owner + 1) % N;
            m_owner = -1;
         end else if (t == 2'b01 || t == 2'b11) begin
            m_err = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   always @(negedge clk) begin
      if (valid_o === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL data_o: unexpected valid flit %h at %0t", data_o, $time);
         end else begin
            mon_exp = sb.pop_front();
            chk("data_o", 32'(data_o), 32'(mon_exp));
         end
      end
   end

   initial begin
      int guard;
      rst = 1'b1;
      ready_i = 1'b1;
      data_i = '0;
      data_i[0 +: W] = 16'h4000;
      req_i = 5'b00001;
      #12;
      chk("rst_pop", 32'(pop_req_o), 0);
      chk("rst_grant", 32'(grant_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_data", 32'(data_o), 0);
      chk("rst_err", 32'(proto_err_o), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive();

      // single flit from queue 0
      fq[0].push_back(16'hC123);
      drive();
      run(3);

      // wormhole lock on queue 2 while queue 0 keeps requesting
      fq[2].push_back(16'h4001);
      fq[2].push_back(16'h0002);
      fq[2].push_back(16'h8003);
      for (int i = 0; i < 3; i++) push_pkt(0, 1);
      drive();
      run(8);

      // round-robin rotation over five single-flit streams
      for (int k = 0; k < N; k++) begin
         push_pkt(k, 1);
         push_pkt(k, 1);
      end
      drive();
      run(12);

      // backpressure in the middle of a packet
      push_pkt(1, 5);
      drive();
      run(2);
      ready_pct = 0;
      drive();
      run(3);
      ready_pct = 100;
      drive();
      run(6);

      // protocol error: body flit at the head while idle
      run(2);
      fq[1].push_back(16'h0055);
      drive();
      run(3);
      fq[1].delete();
      drive();
      run(2);
      rst = 1'b1;
      sb.delete();
      run(2);
      rst = 1'b0;
      run(2);

      // reset asserted after the head of queue 3 is popped
      push_pkt(3, 4);
      drive();
      guard = 0;
      while (m_owner != 3 && guard < 10) begin
         step();
         guard++;
      end
      chk("lock_q3", 32'(m_owner), 3);
      #2;
      rst = 1'b1;
      #1;
      chk("async_pop", 32'(pop_req_o), 0);
      chk("async_grant", 32'(grant_o), 0);
      chk("async_busy", 32'(busy_o), 0);
      chk("async_valid", 32'(valid_o), 0);
      chk("async_data", 32'(data_o), 0);
      chk("async_err", 32'(proto_err_o), 0);
      m_owner = -1;
      m_rr = 0;
      m_err = 1'b0;
      sb.delete();
      fq[3].delete();
      push_pkt(0, 3);
      push_pkt(2, 2);
      drive();
      run(2);
      rst = 1'b0;
      run(8);

      // randomized traffic with backpressure and starvation bubbles
      hide_pct = 20;
      ready_pct = 70;
      drive();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(9) == 0) begin
            int k;
            k = int'($urandom_range(N - 1));
            if (fq[k].size() < 12) push_pkt(k, int'($urandom_range(5, 1)));
         end
         step();
      end
      hide_pct = 0;
      ready_pct = 100;
      drive();
      run(120);
      chk("scoreboard_empty", 32'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
